req_gnt_responder: RTL and testbench

Responder end of the cstart/req/gnt handshake: detects a transaction start (`cstart`), qualifies the request (`req`), and returns a single-cycle `gnt` exactly `GNT_DLY` clocks after the qualifying `req`. It is the design-side counterpart to the overlap/non-overlap request-grant checkers, and their `assert`/`cover` properties bind directly to its ports. It also reports protocol errors and keeps transaction statistics.

---
 rtl/req_gnt_pkg.sv | 14 +
 rtl/sat_counter.sv | 21 ++
 rtl/req_gnt_responder.sv | 119 +++++++++++
 tb/tb_req_gnt_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/req_gnt_pkg.sv
// Shared definitions for the cstart/req/gnt responder: FSM state encoding,
// the legal grant-delay ceiling and the width of the grant delay counter.
package req_gnt_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_REQ = 2'd1,
        DELAY    = 2'd2
    } rg_state_e;

    localparam int RG_MAX_DLY = 15;
    localparam int RG_DLY_W   = 4;

endpackage : req_gnt_pkg

// File: rtl/sat_counter.sv
// Saturating event counter: counts single-cycle 'inc' pulses, sticks at
// all-ones instead of wrapping, and clears synchronously on 'clr'.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on each pulse until every bit is set, then hold
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule : sat_counter

// File: rtl/req_gnt_responder.sv
// Responder side of the cstart/req/gnt handshake. A qualified request is
// answered by a one-cycle grant GNT_DLY clocks later; protocol errors are
// flagged with a one-cycle err pulse, and grants/errors are tallied in
// saturating counters.
module req_gnt_responder
    import req_gnt_pkg::*;
#(
    parameter bit OVERLAP = 1'b1,
    parameter int GNT_DLY = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cstart,
    input  logic             req,
    output logic             gnt,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] txn_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    // An out-of-range delay cannot be represented by the delay counter
    if ((GNT_DLY < 1) || (GNT_DLY > RG_MAX_DLY)) begin : g_bad_gnt_dly
        $fatal(1, "req_gnt_responder: GNT_DLY must lie in 1..%0d", RG_MAX_DLY);
    end

    localparam logic [1:0] ST_IDLE     = IDLE;
    localparam logic [1:0] ST_WAIT_REQ = WAIT_REQ;
    localparam logic [1:0] ST_DELAY    = DELAY;

    // Value loaded when a request qualifies; the grant fires when the count
    // would reach zero, so a load of zero means the grant is issued at once.
    localparam logic [RG_DLY_W-1:0] DLY_LOAD = RG_DLY_W'(GNT_DLY - 1);

    logic [1:0]          state;
    logic [RG_DLY_W-1:0] dly_cnt;
    logic                can_start;

    // A new start is legal when idle, or on the edge the grant is sampled
    // high so back-to-back transactions are possible.
    always_comb begin
        can_start = (state == ST_IDLE) || ((state == ST_DELAY) && gnt);
    end

    // Handshake FSM, grant delay counter and registered gnt/err pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            dly_cnt <= '0;
            gnt     <= 1'b0;
            err     <= 1'b0;
        end else begin
            gnt <= 1'b0;
            err <= 1'b0;
            if (can_start) begin
                state <= ST_IDLE;
                if (cstart) begin
                    if (OVERLAP) begin
                        if (req) begin
                            state   <= ST_DELAY;
                            dly_cnt <= DLY_LOAD;
                            gnt     <= (DLY_LOAD == '0);
                        end else begin
                            err <= 1'b1;
                        end
                    end else begin
                        state <= ST_WAIT_REQ;
                    end
                end
            end else begin
                if (cstart) begin
                    err <= 1'b1;
                end
                case (state)
                    ST_WAIT_REQ: begin
                        if (req) begin
                            state   <= ST_DELAY;
                            dly_cnt <= DLY_LOAD;
                            gnt     <= (DLY_LOAD == '0);
                        end else begin
                            state <= ST_IDLE;
                            err   <= 1'b1;
                        end
                    end
                    ST_DELAY: begin
                        dly_cnt <= dly_cnt - RG_DLY_W'(1);
                        if (dly_cnt == RG_DLY_W'(1)) begin
                            gnt <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Busy covers every cycle a transaction is in flight, including the grant cycle
    always_comb begin
        busy = (state != ST_IDLE);
    end

    sat_counter #(.W(CNT_W)) u_txn_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (gnt),
        .count (txn_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (err),
        .count (err_cnt)
    );

endmodule : req_gnt_responder

// File: tb/tb_req_gnt_responder.sv
// Bench for req_gnt_responder: three instances with different OVERLAP,
// GNT_DLY and CNT_W share one stimulus stream. A timeline model predicts,
// per sample edge, every output of every instance from the handshake rules.
module tb_req_gnt_responder;

    localparam int NC = 4000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cstart = 1'b0;
    logic req = 1'b0;

    logic       gnt0, busy0, err0;
    logic [7:0] txn0, errc0;
    logic       gnt1, busy1, err1;
    logic [7:0] txn1, errc1;
    logic       gnt2, busy2, err2;
    logic [1:0] txn2, errc2;

    logic       act_gnt[3];
    logic       act_busy[3];
    logic       act_err[3];
    logic [7:0] act_txn[3];
    logic [7:0] act_errc[3];

    // Per-instance configuration as the model sees it
    int p_ovl[3] = '{1, 0, 1};
    int p_dly[3] = '{2, 3, 1};
    int p_max[3] = '{255, 255, 3};

    // Expected values indexed by the edge at which they are sampled
    bit exp_gnt[3][NC];
    bit exp_busy[3][NC];
    bit exp_err[3][NC];
    int exp_txn[3][NC];
    int exp_errc[3][NC];

    int m_start[3];
    int m_gedge[3];

    int cyc = 0;
    int last_e = 0;
    int cmp_idx = 0;
    bit chk_en = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    int t = 0;

    req_gnt_responder #(.OVERLAP(1'b1), .GNT_DLY(2), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst(rst), .cstart(cstart), .req(req),
        .gnt(gnt0), .busy(busy0), .err(err0), .txn_cnt(txn0), .err_cnt(errc0)
    );

    req_gnt_responder #(.OVERLAP(1'b0), .GNT_DLY(3), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .cstart(cstart), .req(req),
        .gnt(gnt1), .busy(busy1), .err(err1), .txn_cnt(txn1), .err_cnt(errc1)
    );

    req_gnt_responder #(.OVERLAP(1'b1), .GNT_DLY(1), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .cstart(cstart), .req(req),
        .gnt(gnt2), .busy(busy2), .err(err2), .txn_cnt(txn2), .err_cnt(errc2)
    );

    assign act_gnt[0]  = gnt0;
    assign act_gnt[1]  = gnt1;
    assign act_gnt[2]  = gnt2;
    assign act_busy[0] = busy0;
    assign act_busy[1] = busy1;
    assign act_busy[2] = busy2;
    assign act_err[0]  = err0;
    assign act_err[1]  = err1;
    assign act_err[2]  = err2;
    assign act_txn[0]  = txn0;
    assign act_txn[1]  = txn1;
    assign act_txn[2]  = {6'b0, txn2};
    assign act_errc[0] = errc0;
    assign act_errc[1] = errc1;
    assign act_errc[2] = {6'b0, errc2};

    // Free-running clock
    always #5 clk = ~clk;

    // Edge counter: after the n-th rising edge cyc equals n
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int e,
                               input logic [31:0] actual, input int expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s @edge %0d: got %0d, expected %0d", name, e, actual, expected);
        end
    endtask

    function automatic int satAdd(input int c, input bit inc, input int cmax);
        int r;
        r = c + int'(inc);
        if (r > cmax) r = cmax;
        return r;
    endfunction

    // A qualified request at edge e: grant sampled at e + GNT_DLY, busy until then
    task automatic scheduleGrant(input int i, input int e);
        m_gedge[i] = e + p_dly[i];
        exp_gnt[i][m_gedge[i]] = 1'b1;
        for (int j = e + 1; j <= m_gedge[i]; j++) exp_busy[i][j] = 1'b1;
    endtask

    // Advance the timeline model with the inputs sampled at edge e
    task automatic modelStep(input int e, input bit cs, input bit rq, input bit rs);
        for (int i = 0; i < 3; i++) begin
            bit errn;
            bit inflight;
            errn = 1'b0;
            if (rs) begin
                exp_txn[i][e+1]  = 0;
                exp_errc[i][e+1] = 0;
                for (int j = e + 1; j < e + 20; j++) begin
                    exp_gnt[i][j]  = 1'b0;
                    exp_err[i][j]  = 1'b0;
                    exp_busy[i][j] = 1'b0;
                end
                m_start[i] = -1;
                m_gedge[i] = 0;
            end else begin
                exp_txn[i][e+1]  = satAdd(exp_txn[i][e], exp_gnt[i][e], p_max[i]);
                exp_errc[i][e+1] = satAdd(exp_errc[i][e], exp_err[i][e], p_max[i]);
                inflight = (m_start[i] >= 0) && !((m_gedge[i] != 0) && (e >= m_gedge[i]));
                if (inflight) begin
                    if (cs) errn = 1'b1;
                    if ((m_gedge[i] == 0) && (e == m_start[i] + 1)) begin
                        if (rq) begin
                            scheduleGrant(i, e);
                        end else begin
                            errn = 1'b1;
                            m_start[i] = -1;
                        end
                    end
                end else begin
                    m_start[i] = -1;
                    m_gedge[i] = 0;
                    if (cs) begin
                        if (p_ovl[i] != 0) begin
                            if (rq) begin
                                m_start[i] = e;
                                scheduleGrant(i, e);
                            end else begin
                                errn = 1'b1;
                            end
                        end else begin
                            m_start[i] = e;
                            exp_busy[i][e+1] = 1'b1;
                        end
                    end
                end
                exp_err[i][e+1] = errn;
            end
        end
    endtask

    // Drive one cycle of inputs just after a rising edge and update the model
    task automatic applyStimulus(input bit cs, input bit rq, input bit rs);
        @(posedge clk);
        #1;
        cstart = cs;
        req    = rq;
        rst    = rs;
        last_e = cyc + 1;
        modelStep(last_e, cs, rq, rs);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    // Compare every instance against the model once per cycle, mid-period
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_idx = cyc + 1;
            for (int i = 0; i < 3; i++) begin
                checkOutput($sformatf("gnt%0d", i),     cmp_idx, act_gnt[i],  exp_gnt[i][cmp_idx]);
                checkOutput($sformatf("busy%0d", i),    cmp_idx, act_busy[i], exp_busy[i][cmp_idx]);
                checkOutput($sformatf("err%0d", i),     cmp_idx, act_err[i],  exp_err[i][cmp_idx]);
                checkOutput($sformatf("txn_cnt%0d", i), cmp_idx, act_txn[i],  exp_txn[i][cmp_idx]);
                checkOutput($sformatf("err_cnt%0d", i), cmp_idx, act_errc[i], exp_errc[i][cmp_idx]);
            end
        end
    end

    // Directed handshake scenarios, then a long randomized run
    initial begin
        for (int i = 0; i < 3; i++) begin
            m_start[i] = -1;
            m_gedge[i] = 0;
        end

        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        idle(3);

        // Overlapped start with request
        applyStimulus(1'b1, 1'b1, 1'b0);
        t = last_e;
        idle(5);
        checkOutput("pin_ovl_gnt_t1",  t, exp_gnt[0][t+1],  0);
        checkOutput("pin_ovl_gnt_t2",  t, exp_gnt[0][t+2],  1);
        checkOutput("pin_ovl_gnt_t3",  t, exp_gnt[0][t+3],  0);
        checkOutput("pin_ovl_busy_t1", t, exp_busy[0][t+1], 1);
        checkOutput("pin_ovl_busy_t2", t, exp_busy[0][t+2], 1);
        checkOutput("pin_ovl_busy_t3", t, exp_busy[0][t+3], 0);
        checkOutput("pin_ovl_txn",     t, exp_txn[0][t+3],  1);
        checkOutput("pin_novl_err",    t, exp_err[1][t+2],  1);
        checkOutput("pin_novl_errcnt", t, exp_errc[1][t+3], 1);
        checkOutput("pin_dly1_gnt",    t, exp_gnt[2][t+1],  1);

        // Non-overlapped start with request one cycle later
        applyStimulus(1'b1, 1'b0, 1'b0);
        t = last_e;
        applyStimulus(1'b0, 1'b1, 1'b0);
        idle(6);
        checkOutput("pin_novl_gnt",    t, exp_gnt[1][t+4],  1);
        checkOutput("pin_novl_noerr",  t, exp_err[1][t+2],  0);
        checkOutput("pin_ovl_missreq", t, exp_err[0][t+1],  1);

        // Second start while busy
        applyStimulus(1'b1, 1'b1, 1'b0);
        t = last_e;
        applyStimulus(1'b1, 1'b0, 1'b0);
        idle(4);
        checkOutput("pin_coll_err", t, exp_err[0][t+2], 1);
        checkOutput("pin_coll_gnt", t, exp_gnt[0][t+2], 1);

        // Back-to-back starts two cycles apart
        applyStimulus(1'b1, 1'b1, 1'b0);
        t = last_e;
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        idle(4);
        checkOutput("pin_b2b_gnt",   t, exp_gnt[0][t+4],  1);
        checkOutput("pin_b2b_busy",  t, exp_busy[0][t+3], 1);
        checkOutput("pin_b2b_noerr", t, exp_err[0][t+3],  0);

        // Reset one cycle after a start
        applyStimulus(1'b1, 1'b1, 1'b0);
        t = last_e;
        applyStimulus(1'b0, 1'b0, 1'b1);
        idle(3);
        checkOutput("pin_rst_nognt",  t, exp_gnt[0][t+2],  0);
        checkOutput("pin_rst_nobusy", t, exp_busy[0][t+2], 0);

        // Six consecutive grants on the two-bit counter instance
        for (int k = 0; k < 6; k++) applyStimulus(1'b1, 1'b1, 1'b0);
        idle(3);
        checkOutput("pin_sat_model", last_e, exp_txn[2][last_e], 3);
        checkOutput("sat_txn_cnt",   last_e, act_txn[2],         3);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 2500; k++) begin
            applyStimulus($urandom_range(0, 99) < 35,
                          $urandom_range(0, 99) < 70,
                          $urandom_range(0, 199) == 0);
        end
        idle(20);

        @(negedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_req_gnt_responder
